mdm_unit: RTL

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline; consumes the MDM* control bundle produced by the decode controller together with the forwarded RS/RT operands. Owns the HI/LO registers. Runs MULT/MULTU/DIV/DIVU as fixed-latency multicycle operations. Services MTHI/MTLO writes and MFHI/MFLO reads. Exports a busy indication that the hazard unit uses to stall any following MDM instruction in D.

---
 rtl/mdm_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mdm_unit.sv
// ---------------------------------------------------------------------------
// mdm_unit
//
// Multiply/divide unit of the EX stage. Owns the architectural HI/LO
// registers and executes MULT/MULTU/DIV/DIVU as fixed-latency multicycle
// operations. It also services MTHI/MTLO writes and MFHI/MFLO reads.
//
// Parameters:
//   MULT_CYCLES  busy cycles after the start cycle for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles after the start cycle for DIV/DIVU  (1..15)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset; clears all state
//   Start  begin MULT/MULTU/DIV/DIVU this cycle
//   Op     000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 1xx move (MT/MF)
//   Write  MTHI/MTLO write this cycle
//   Addr   0 = HI, 1 = LO (write target and read source)
//   Kill   exception taken this cycle; suppresses Start and Write
//   A      RS operand (multiplicand / dividend / MT data)
//   B      RT operand (multiplier / divisor)
//   Busy   (Start & !Kill) | running; combinational, feeds the hazard unit
//   HI     committed HI register
//   LO     committed LO register
//   Out    Addr ? LO : HI; combinational MFHI/MFLO data
// ---------------------------------------------------------------------------
module mdm_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic        Write,
    input  logic        Addr,
    input  logic        Kill,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    // The down-counter is 4 bits wide, so each latency must fit in 1..15.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [1:0]  op_reg;      // [1] = divide, [0] = signed
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        busy_q;
    logic        start_ok;
    logic        write_ok;

    // Op[2] only distinguishes move instructions, which reach this unit
    // through Write/Addr; an arithmetic start only needs Op[1:0].
    logic        unused_op;
    assign unused_op = Op[2];

    assign busy_q   = (state_reg == RUN);
    assign start_ok = Start & ~Kill;
    assign write_ok = Write & ~Kill & ~Start;

    assign Busy = start_ok | busy_q;
    assign HI   = hi_reg;
    assign LO   = lo_reg;
    assign Out  = Addr ? lo_reg : hi_reg;

    // -----------------------------------------------------------------------
    // Result datapath, driven only by the latched operands so that operand
    // changes on A/B while running cannot disturb the result.
    // -----------------------------------------------------------------------

    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
    // product are then correct for both signed and unsigned operands.
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    assign a_ext   = {{32{op_reg[0] & a_reg[31]}}, a_reg};
    assign b_ext   = {{32{op_reg[0] & b_reg[31]}}, b_reg};
    assign product = a_ext * b_ext;

    // Divide: work on magnitudes, then restore signs. The quotient is
    // negative when exactly one operand is negative (truncation toward
    // zero), the remainder takes the dividend's sign. Magnitude of
    // 0x80000000 is 2^31 as an unsigned value, which makes
    // 0x80000000 / -1 wrap back to 0x80000000 with remainder 0.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    assign a_neg       = op_reg[0] & a_reg[31];
    assign b_neg       = op_reg[0] & b_reg[31];
    assign a_mag       = a_neg ? (32'd0 - a_reg) : a_reg;
    assign b_mag       = b_neg ? (32'd0 - b_reg) : b_reg;
    assign div_by_zero = (b_reg == 32'd0);
    // Keep the divider free of a zero divisor; the result is discarded then.
    assign b_safe      = div_by_zero ? 32'd1 : b_mag;
    assign q_mag       = a_mag / b_safe;
    assign r_mag       = a_mag % b_safe;
    assign quotient    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign remainder   = a_neg ? (32'd0 - r_mag) : r_mag;

    // -----------------------------------------------------------------------
    // Control FSM and architectural state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            op_reg    <= 2'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Start wins over Write when both are present.
                    if (start_ok) begin
                        op_reg    <= Op[1:0];
                        a_reg     <= A;
                        b_reg     <= B;
                        cnt_reg   <= Op[1] ? DIV_LOAD : MULT_LOAD;
                        state_reg <= RUN;
                    end else if (write_ok) begin
                        if (Addr) begin
                            lo_reg <= A;
                        end else begin
                            hi_reg <= A;
                        end
                    end
                end

                RUN: begin
                    // Start, Write and Kill are all ignored while running.
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= IDLE;
                        if (!op_reg[1]) begin
                            hi_reg <= product[63:32];
                            lo_reg <= product[31:0];
                        end else if (!div_by_zero) begin
                            hi_reg <= remainder;
                            lo_reg <= quotient;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
